// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
//   - state_t     : arbiter FSM states
//   - DEF_*       : default core count and bus widths
//   - idx_w()     : width of an index into n items (at least 1 bit)
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam int DEF_NCORES = 4;
    localparam int DEF_AW     = 16;
    localparam int DEF_DW     = 16;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_IDX_W = idx_w(DEF_NCORES);

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the per-core request/ack signals and the RAM port.
//   slave  : the arbiter (consumes requests and RAM read data,
//            drives acks, read data and the RAM strobes)
//   master : the environment (cores plus RAM)
//   req_rd/req_wr  per-core level requests, req_addr/req_wdata packed per core
//   core_ack/core_rdata per-core completion pulse and read-data register
//   mem_addr/mem_wdata/mem_re/mem_we/mem_rdata single-port RAM interface
interface dmem_arbiter_if
    import dmem_pkg::*;
#(
    parameter int NCORES = DEF_NCORES,
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW
);
    logic [NCORES-1:0]    req_rd;
    logic [NCORES-1:0]    req_wr;
    logic [NCORES*AW-1:0] req_addr;
    logic [NCORES*DW-1:0] req_wdata;
    logic [NCORES-1:0]    core_ack;
    logic [NCORES*DW-1:0] core_rdata;
    logic [AW-1:0]        mem_addr;
    logic [DW-1:0]        mem_wdata;
    logic                 mem_re;
    logic                 mem_we;
    logic [DW-1:0]        mem_rdata;

    modport slave (
        input  req_rd, req_wr, req_addr, req_wdata, mem_rdata,
        output core_ack, core_rdata, mem_addr, mem_wdata, mem_re, mem_we
    );

    modport master (
        output req_rd, req_wr, req_addr, req_wdata, mem_rdata,
        input  core_ack, core_rdata, mem_addr, mem_wdata, mem_re, mem_we
    );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set bit of req searching
// ptr, ptr+1, ... wrapping modulo N.
//   req    : request vector (bit i = requester i)
//   ptr    : highest-priority index this round (< N)
//   winner : chosen index (0 when nothing is requested)
//   valid  : at least one request is set
module rr_arbiter
    import dmem_pkg::*;
#(
    parameter int N  = DEF_NCORES,
    parameter int IW = DEF_IDX_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] winner,
    output logic          valid
);

    // One extra bit so ptr+i cannot overflow before the modulo fold.
    logic [IW:0] sum;

    always_comb begin
        valid  = 1'b0;
        winner = '0;
        sum    = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (IW+1)'(i);
            if (sum >= (IW+1)'(N))
                sum = sum - (IW+1)'(N);
            if (!valid && req[sum[IW-1:0]]) begin
                valid  = 1'b1;
                winner = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shared data-memory arbiter: serialises per-core read/write requests
// onto one single-port RAM with round-robin priority and returns a
// one-cycle ack plus a per-core read-data register.
//   clk  : system clock
//   rst  : asynchronous active-high reset, drops any in-flight access
//   bus  : request/ack and RAM signals (slave side)
//   busy : high whenever the FSM is not in IDLE
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int NCORES = DEF_NCORES,
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus,
    output logic           busy
);

    localparam int IW = idx_w(NCORES);
    localparam int CW = idx_w(RD_LAT);

    state_t               state, next_state;
    logic [IW-1:0]        ptr;
    logic [IW-1:0]        winner;
    logic [IW-1:0]        pick;
    logic                 pick_vld;
    logic [NCORES-1:0]    req_any;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_wdata;
    logic                 sel_wr;
    logic [AW-1:0]        lat_addr;
    logic [DW-1:0]        lat_wdata;
    logic                 lat_wr;
    logic [CW-1:0]        cnt;
    logic [NCORES*DW-1:0] rdata_q;
    logic [NCORES-1:0]    ack;
    logic                 re;
    logic                 we;

    assign req_any = bus.req_rd | bus.req_wr;

    rr_arbiter #(.N(NCORES), .IW(IW)) u_rr (
        .req    (req_any),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_vld)
    );

    // Fields of the core picked this cycle. A core raising both read and
    // write is treated as a write.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int i = 0; i < NCORES; i++) begin
            if (pick == IW'(i)) begin
                sel_addr  = bus.req_addr[i*AW +: AW];
                sel_wdata = bus.req_wdata[i*DW +: DW];
                sel_wr    = bus.req_wr[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pick_vld) next_state = ISSUE;
            ISSUE:   next_state = lat_wr ? ACK : WAIT;
            WAIT:    if (cnt == '0) next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transaction registers. The request is latched once in IDLE; later
    // changes on the core side are not seen until the next IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            winner    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wr    <= 1'b0;
            cnt       <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        winner    <= pick;
                        lat_addr  <= sel_addr;
                        lat_wdata <= sel_wdata;
                        lat_wr    <= sel_wr;
                    end
                end
                ISSUE: begin
                    if (winner == IW'(NCORES-1))
                        ptr <= '0;
                    else
                        ptr <= winner + IW'(1);
                    if (!lat_wr)
                        cnt <= CW'(RD_LAT-1);
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        for (int i = 0; i < NCORES; i++) begin
                            if (winner == IW'(i))
                                rdata_q[i*DW +: DW] <= bus.mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        re  = 1'b0;
        we  = 1'b0;
        ack = '0;
        case (state)
            ISSUE: begin
                we = lat_wr;
                re = !lat_wr;
            end
            ACK: begin
                for (int i = 0; i < NCORES; i++)
                    ack[i] = (winner == IW'(i));
            end
            default: ;
        endcase
    end

    // Address/data come straight from the latched request, so they stay
    // put through WAIT and read as zero after reset.
    assign bus.mem_addr   = lat_addr;
    assign bus.mem_wdata  = lat_wdata;
    assign bus.mem_re     = re;
    assign bus.mem_we     = we;
    assign bus.core_ack   = ack;
    assign bus.core_rdata = rdata_q;
    assign busy           = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: one 4-core instance with RD_LAT=1 backed by
// a small RAM model, and one with RD_LAT=3 for the mid-read reset case.
module tb_dmem_arbiter;

    typedef struct {
        int          core;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst3;
    logic busy;
    logic busy3;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.NCORES(4), .AW(16), .DW(16)) bus  ();
    dmem_arbiter_if #(.NCORES(4), .AW(16), .DW(16)) bus3 ();

    dmem_arbiter #(.NCORES(4), .AW(16), .DW(16), .RD_LAT(1)) dut (
        .clk (clk), .rst (rst), .bus (bus), .busy (busy)
    );

    dmem_arbiter #(.NCORES(4), .AW(16), .DW(16), .RD_LAT(3)) dut3 (
        .clk (clk), .rst (rst3), .bus (bus3), .busy (busy3)
    );

    // RAM for the main instance: 256 words, one-cycle read latency.
    logic [15:0] ram [0:255];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;
    logic [15:0] rd_q;

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
        if (pre_we)     ram[pre_addr] <= pre_data;
        if (bus.mem_re) rd_q <= ram[bus.mem_addr[7:0]];
    end
    assign bus.mem_rdata = rd_q;

    // ROM-like RAM for the RD_LAT=3 instance: contents are f3(addr).
    function automatic logic [15:0] f3(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    logic [15:0] p0, p1, p2;
    always @(posedge clk) begin
        p0 <= bus3.mem_re ? f3(bus3.mem_addr) : 16'h0;
        p1 <= p0;
        p2 <= p1;
    end
    assign bus3.mem_rdata = p2;

    exp_t        q[$];
    exp_t        q3[$];
    logic [15:0] shadow  [0:3];
    logic [15:0] shadow3 [0:3];
    int          checks = 0;
    int          errors = 0;
    int          re_cnt, we_cnt, ack_cnt;
    logic [3:0]  prev_ack, prev_ack3;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic handle(input int inst, input logic [3:0] ack, input logic [3:0] pack,
                          input logic [63:0] rd);
        exp_t       e;
        logic [1:0] c;
        bit         empty;
        if (ack == 4'b0) return;
        chk($sformatf("i%0d_ack_onehot", inst), 32'($onehot(ack)), 32'd1);
        chk($sformatf("i%0d_ack_single", inst), 32'(pack), 32'd0);
        empty = (inst == 0) ? (q.size() == 0) : (q3.size() == 0);
        if (empty) begin
            chk($sformatf("i%0d_unexpected_ack", inst), 32'(ack), 32'd0);
        end else begin
            if (inst == 0) e = q.pop_front();
            else           e = q3.pop_front();
            c = 2'(e.core);
            chk($sformatf("i%0d_ack_core", inst), 32'(ack), 32'(4'(4'b1 << c)));
            if (e.rd) begin
                if (inst == 0) shadow[c]  = e.data;
                else           shadow3[c] = e.data;
            end
            for (int i = 0; i < 4; i++) begin
                c = 2'(i);
                chk($sformatf("i%0d_rdata_core%0d", inst, i), 32'(rd[{c, 4'b0} +: 16]),
                    32'((inst == 0) ? shadow[c] : shadow3[c]));
            end
        end
        if (inst == 0) begin
            bus.req_rd = bus.req_rd & ~ack;
            bus.req_wr = bus.req_wr & ~ack;
        end else begin
            bus3.req_rd = bus3.req_rd & ~ack;
            bus3.req_wr = bus3.req_wr & ~ack;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.mem_re || bus.mem_we)
            chk("re_we_excl", 32'(bus.mem_re & bus.mem_we), 32'd0);
        if (bus3.mem_re || bus3.mem_we)
            chk("i1_re_we_excl", 32'(bus3.mem_re & bus3.mem_we), 32'd0);
        if (bus.mem_re) re_cnt++;
        if (bus.mem_we) we_cnt++;
        if (bus.core_ack != 4'b0) ack_cnt++;
        handle(0, bus.core_ack, prev_ack, bus.core_rdata);
        prev_ack = bus.core_ack;
        handle(1, bus3.core_ack, prev_ack3, bus3.core_rdata);
        prev_ack3 = bus3.core_ack;
    endtask

    task automatic req(input int inst, input int core, input bit rd, input bit wr,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [15:0] expd);
        logic [1:0] c;
        logic [3:0] m;
        exp_t       e;
        c = 2'(core);
        m = 4'(4'b1 << c);
        e = '{core, rd && !wr, expd};
        if (inst == 0) begin
            bus.req_addr[{c, 4'b0} +: 16]  = addr;
            bus.req_wdata[{c, 4'b0} +: 16] = wdata;
            if (rd) bus.req_rd = bus.req_rd | m;
            if (wr) bus.req_wr = bus.req_wr | m;
            q.push_back(e);
        end else begin
            bus3.req_addr[{c, 4'b0} +: 16]  = addr;
            bus3.req_wdata[{c, 4'b0} +: 16] = wdata;
            if (rd) bus3.req_rd = bus3.req_rd | m;
            if (wr) bus3.req_wr = bus3.req_wr | m;
            q3.push_back(e);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [15:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        cyc();
        pre_we   = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (q.size() == 0 && q3.size() == 0 && !busy && !busy3) break;
            cyc();
        end
        chk("drain_q", 32'(q.size()), 32'd0);
        chk("drain_q3", 32'(q3.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;  rst3 = 1'b1;
        bus.req_rd = '0;  bus.req_wr = '0;  bus.req_addr = '0;  bus.req_wdata = '0;
        bus3.req_rd = '0; bus3.req_wr = '0; bus3.req_addr = '0; bus3.req_wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        prev_ack = '0; prev_ack3 = '0;
        re_cnt = 0; we_cnt = 0; ack_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            shadow[i]  = 16'h0;
            shadow3[i] = 16'h0;
        end

        // Preload RAM while held in reset
        for (int i = 0; i < 4; i++) preload(8'(8'h20 + i), 16'(16'hA000 + i));
        preload(8'h40, 16'hBEEF);

        // Reset state
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ack",   32'(bus.core_ack), 32'd0);
        chk("rst_re",    32'(bus.mem_re), 32'd0);
        chk("rst_we",    32'(bus.mem_we), 32'd0);
        chk("rst_addr",  32'(bus.mem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_rdata_lo", bus.core_rdata[31:0], 32'd0);
        chk("rst_rdata_hi", bus.core_rdata[63:32], 32'd0);
        chk("rst3_busy", 32'(busy3), 32'd0);

        // Round robin: all cores request from reset; core0 re-requests after its ack
        for (int i = 0; i < 4; i++) req(0, i, 1'b1, 1'b0, 16'(16'h20 + i), 16'h0, 16'(16'hA000 + i));
        rst = 1'b0; rst3 = 1'b0;
        for (int k = 0; k < 40 && q.size() != 3; k++) cyc();
        req(0, 0, 1'b1, 1'b0, 16'h0020, 16'h0, 16'hA000);
        drain(60);

        // Single read, core1
        req(0, 1, 1'b1, 1'b0, 16'h0040, 16'h0, 16'hBEEF);
        cyc();
        chk("rd_c1_re",   32'(bus.mem_re), 32'd1);
        chk("rd_c1_we",   32'(bus.mem_we), 32'd0);
        chk("rd_c1_addr", 32'(bus.mem_addr), 32'h40);
        cyc();
        chk("rd_c2_ack",  32'(bus.core_ack), 32'd0);
        cyc();
        chk("rd_c3_ack",  32'(bus.core_ack), 32'h2);
        chk("rd_c3_data", 32'(bus.core_rdata[31:16]), 32'hBEEF);
        drain(10);

        // Single write, core2, then read back
        req(0, 2, 1'b0, 1'b1, 16'h0010, 16'h1234, 16'h0);
        cyc();
        chk("wr_c1_we",    32'(bus.mem_we), 32'd1);
        chk("wr_c1_re",    32'(bus.mem_re), 32'd0);
        chk("wr_c1_addr",  32'(bus.mem_addr), 32'h10);
        chk("wr_c1_wdata", 32'(bus.mem_wdata), 32'h1234);
        cyc();
        chk("wr_c2_ack",   32'(bus.core_ack), 32'h4);
        drain(10);
        req(0, 2, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h1234);
        drain(10);

        // Pointer fairness: core3 served, then cores 0 and 3 together -> 0 first
        req(0, 3, 1'b1, 1'b0, 16'h0023, 16'h0, 16'hA003);
        drain(10);
        req(0, 0, 1'b1, 1'b0, 16'h0020, 16'h0, 16'hA000);
        req(0, 3, 1'b1, 1'b0, 16'h0023, 16'h0, 16'hA003);
        drain(20);

        // Read and write together from core0: only a write, one ack
        re_cnt = 0; we_cnt = 0; ack_cnt = 0;
        req(0, 0, 1'b1, 1'b1, 16'h0050, 16'h7777, 16'h0);
        drain(10);
        for (int k = 0; k < 3; k++) cyc();
        chk("conf_re_cnt",  32'(re_cnt), 32'd0);
        chk("conf_we_cnt",  32'(we_cnt), 32'd1);
        chk("conf_ack_cnt", 32'(ack_cnt), 32'd1);
        req(0, 1, 1'b1, 1'b0, 16'h0050, 16'h0, 16'h7777);
        drain(10);

        // RD_LAT=3 instance: full read, ack at +5
        req(1, 0, 1'b1, 1'b0, 16'h0033, 16'h0, f3(16'h0033));
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk($sformatf("lat3_noack_c%0d", k), 32'(bus3.core_ack), 32'd0);
        end
        cyc();
        chk("lat3_ack_c5", 32'(bus3.core_ack), 32'h1);
        drain(10);

        // Reset in WAIT: everything clears at once, no ack follows
        bus3.req_addr[31:16] = 16'h0044;
        bus3.req_rd = 4'b0010;
        cyc();
        cyc();
        chk("mid_busy_wait", 32'(busy3), 32'd1);
        rst3 = 1'b1;
        bus3.req_rd = 4'b0;
        #1;
        chk("mid_rst_busy",  32'(busy3), 32'd0);
        chk("mid_rst_ack",   32'(bus3.core_ack), 32'd0);
        chk("mid_rst_re",    32'(bus3.mem_re), 32'd0);
        chk("mid_rst_we",    32'(bus3.mem_we), 32'd0);
        chk("mid_rst_addr",  32'(bus3.mem_addr), 32'd0);
        chk("mid_rst_wdata", 32'(bus3.mem_wdata), 32'd0);
        chk("mid_rst_rdata_lo", bus3.core_rdata[31:0], 32'd0);
        chk("mid_rst_rdata_hi", bus3.core_rdata[63:32], 32'd0);
        for (int i = 0; i < 4; i++) shadow3[i] = 16'h0;
        cyc();
        cyc();
        rst3 = 1'b0;
        ack_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cyc();
            if (bus3.core_ack != 4'b0) ack_cnt++;
        end
        chk("mid_rst_no_ack", 32'(ack_cnt), 32'd0);
        req(1, 0, 1'b1, 1'b0, 16'h0055, 16'h0, f3(16'h0055));
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shared data-memory arbiter sitting directly downstream of the per-core data ports (DMADDR/DOUT/DIN/MEMREAD/MEMWR) in the multicore datapath.
- Serialises read/write requests from NCORES cores onto one single-port data RAM using round-robin priority.
- Returns per-core read data and a one-cycle acknowledge.
- A core holds its request until it is acknowledged.

Parameters:
- NCORES, 4, number of requesting cores (2..8).
- AW, 16, address width.
- DW, 16, data width.
- RD_LAT, 1, RAM read latency in cycles (>=1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_rd  in  NCORES  per-core read request (level; core i = bit i).
- req_wr  in  NCORES  per-core write request (level).
- req_addr  in  NCORES*AW  per-core address; core i at bits [i*AW +: AW].
- req_wdata  in  NCORES*DW  per-core write data.
- core_ack  out  NCORES  one-cycle completion pulse per core.
- core_rdata  out  NCORES*DW  per-core read-data register, valid from the ack cycle until that core's next read completes.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_re  out  1  RAM read strobe.
- mem_we  out  1  RAM write strobe.
- mem_rdata  in  DW  RAM read data, valid RD_LAT cycles after the mem_re cycle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - state=IDLE, rr pointer=0, wait counter=0.
  - core_ack=0, mem_re=0, mem_we=0, busy=0.
  - mem_addr=0, mem_wdata=0, all core_rdata=0.
  - Any in-flight transaction is dropped; no ack is issued for it.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Active request vector = req_rd | req_wr.
  - If any bit is set, select the winner by round-robin: first set bit searching ptr, ptr+1, … mod NCORES.
  - Latch winner index, address, wdata and op (write if req_wr[winner], else read); go to ISSUE.
  - If no bit is set, stay in IDLE.
- ISSUE (1 cycle):
  - Drive mem_addr and mem_wdata from the latched values.
  - mem_we=1 for a write; mem_re=1 for a read.
  - ptr <= (winner+1) mod NCORES.
  - Write: go to ACK. Read: load counter=RD_LAT-1 and go to WAIT.
- WAIT:
  - mem_re=0; mem_addr held.
  - While counter!=0, decrement.
  - When counter==0, capture mem_rdata into core_rdata[winner] and go to ACK.
- ACK (1 cycle):
  - core_ack[winner]=1, all other ack bits 0; return to IDLE.
- Latency, measured from the IDLE cycle that sees the request:
  - Write: ack at cycle +2.
  - Read: ack at cycle +2+RD_LAT (cycle +3 when RD_LAT=1).
- Requester protocol:
  - Requester samples ack on the rising edge and deasserts its request for the following cycle, so that IDLE never re-grants a completed request.
  - Address and data must be stable from request assertion until ack.
- Simultaneous req_rd and req_wr from the same core: treated as a write; the read is ignored and exactly one ack is issued.
- Requests that appear or change while busy are ignored until the next IDLE evaluation; there is no queuing.
- Pointer wrap: winner NCORES-1 gives ptr=0.
- mem_re and mem_we are never both high.
- core_ack is never high for more than one core or for more than one cycle per transaction.
- core_rdata of non-winning cores is never modified.

Decomposition:
- Shared package (dmem_pkg) holds:
  - State enum: IDLE, ISSUE, WAIT, ACK.
  - Constants: default NCORES, AW, DW.
  - Index width: clog2(NCORES).
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: request vector, ptr.
  - Outputs: winner index and a valid flag.
  - Reused later for the instruction-memory port.

Test Plan:
- Single read: RAM[0x0040]=0xBEEF; core1 asserts req_rd with addr 0x0040.
  - mem_re high at cycle +1 with mem_addr=0x0040.
  - core_ack[1] pulses at cycle +3; core_rdata[1]=0xBEEF.
- Single write: core2 writes 0x1234 to 0x0010.
  - mem_we high one cycle with addr 0x0010, data 0x1234; core_ack[2] at cycle +2.
  - A subsequent read of 0x0010 returns 0x1234.
- Round-robin: all four cores hold req_rd from reset.
  - Grant order is 0,1,2,3,0.
  - Each core is acked exactly once per round; no core starves.
- Pointer fairness: after core3 is served, cores 0 and 3 request together → core0 wins; pointer wraps correctly.
- Read/write conflict: core0 asserts req_rd and req_wr together.
  - Only mem_we is issued; a single ack.
- Reset mid-read: assert rst during WAIT with RD_LAT=3.
  - All outputs go to 0 immediately; no ack follows.
  - After release, a new request from core0 completes normally.
